// File: rtl/mod_n_pkg.sv
// Shared width, reset-value and load-clamp rules for the mod-N counter family.
package mod_n_pkg;

  function automatic int count_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Top-of-range value both counter directions start from / wrap to.
  function automatic int unsigned reset_value(input int unsigned n);
    return n - 1;
  endfunction

  // Compared at 32 bits, so a W-bit load value is never aliased against N,
  // even when N is a power of two.
  function automatic int unsigned clamp_load(input int unsigned value, input int unsigned n);
    return (value >= n) ? n - 1 : value;
  endfunction

endpackage

// File: rtl/mod_n_down.sv
// Mod-N down counter with load, enable, cascade terminal count and wrap pulse.
// Define MOD_N_DOWN_ONESHOT_EN to stop at zero instead of wrapping.
module mod_n_down
  import mod_n_pkg::*;
#(
  parameter int N = 17,
  localparam int W = count_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] out,
  output logic         zero,
  output logic         tc,
  output logic         wrap
);

  localparam logic [W-1:0] RST_VAL = W'(reset_value(N));

  logic [W-1:0] r_out;
  logic         r_wrap;
  logic [W-1:0] w_load_clamped;
  logic         w_zero;

  assign w_load_clamped = W'(clamp_load(32'(load_val), N));
  assign w_zero         = (r_out == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= RST_VAL;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_out  <= w_load_clamped;
      r_wrap <= 1'b0;
    end else if (en) begin
      if (w_zero) begin
`ifdef MOD_N_DOWN_ONESHOT_EN
        r_out  <= '0;
        r_wrap <= 1'b0;
`else
        r_out  <= RST_VAL;
        r_wrap <= 1'b1;
`endif
      end else begin
        r_out  <= r_out - 1'b1;
        r_wrap <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign out  = r_out;
  assign zero = w_zero;
  assign tc   = en & w_zero;
  assign wrap = r_wrap;

endmodule
